// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding, default parameters and clog2 helper for the reset sequencer
package rst_seq_pkg;
  typedef enum logic [1:0] {
    RESET   = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;
  localparam int DEF_NUM_STAGES     = 2;
  localparam int DEF_HOLD_CYCLES    = 4;
  localparam int DEF_NUM_OUT        = 2;
  localparam int DEF_STAGGER_CYCLES = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: NUM_STAGES flop chain shifting in 1s, cleared asynchronously by RST
//   CLK   : domain clock
//   RST   : asynchronous active-low clear
//   o_pen : penultimate tap (feeds the merged final stage in the sequencer)
//   o_fin : final tap
module rst_sync_chain
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES
) (
  input  logic CLK,
  input  logic RST,
  output logic o_pen,
  output logic o_fin
);
  logic [NUM_STAGES-1:0] r_ff;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_ff <= '0;
    else r_ff <= {r_ff[NUM_STAGES-2:0], 1'b1};
  assign o_pen = r_ff[NUM_STAGES-2];
  assign o_fin = r_ff[NUM_STAGES-1];
endmodule

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: reset synchronizer with hold time, staggered ordered release and software reset
//   CLK         : domain clock
//   RST         : asynchronous active-low reset
//   SW_RST_REQ  : synchronous active-high software reset request (level)
//   SYNC_RST    : active-low sequenced resets, bit 0 released first
//   RST_DONE    : all SYNC_RST bits released
//   SW_RST_FLAG : sticky, last sequence was software-initiated
module rst_seq_sync
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int NUM_OUT        = DEF_NUM_OUT,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SW_RST_REQ,
  output logic [NUM_OUT-1:0] SYNC_RST,
  output logic               RST_DONE,
  output logic               SW_RST_FLAG
);
  localparam int MX = HOLD_CYCLES > STAGGER_CYCLES ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW = clog2(MX + 1);
  localparam int IW = NUM_OUT > 1 ? clog2(NUM_OUT) : 1;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          w_pen, w_fin, w_rel, w_last;
  rst_sync_chain #(.NUM_STAGES(NUM_STAGES)) u_chain (
    .CLK  (CLK),
    .RST  (RST),
    .o_pen(w_pen),
    .o_fin(w_fin)
  );
  assign w_last = r_idx == IW'(NUM_OUT - 1);
  // The RESET-exit decision acts as the last chain stage, so with no hold
  // time the first release happens on the edge the chain would complete.
  assign w_rel = r_state == RESET ? (HOLD_CYCLES == 0) && w_pen
                                  : (r_state != RUN) && w_fin && (r_cnt == '0);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_state     <= RESET;
      r_cnt       <= '0;
      r_idx       <= '0;
      SYNC_RST    <= '0;
      RST_DONE    <= 1'b0;
      SW_RST_FLAG <= 1'b0;
    end else if (SW_RST_REQ && r_state != RESET) begin
      r_state     <= HOLD;
      r_cnt       <= CW'(HOLD_CYCLES);
      r_idx       <= '0;
      SYNC_RST    <= '0;
      RST_DONE    <= 1'b0;
      SW_RST_FLAG <= 1'b1;
    end else if (w_rel) begin
      SYNC_RST <= SYNC_RST | (NUM_OUT'(1) << r_idx);
      if (w_last) begin
        r_state  <= RUN;
        RST_DONE <= 1'b1;
      end else begin
        r_state <= RELEASE;
        r_idx   <= r_idx + 1'b1;
        r_cnt   <= CW'(STAGGER_CYCLES - 1);
      end
    end else if (r_state == RESET) begin
      // Entry edge counts as the first hold cycle, hence the minus one.
      if (w_pen) begin
        r_state <= HOLD;
        r_cnt   <= CW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
      end
    end else if (r_state != RUN && w_fin && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: tb/tb_rst_seq_sync.sv
module tb_rst_seq_sync;
  logic CLK = 1'b0, RST = 1'b0, SW = 1'b0;
  logic [1:0] s0;
  logic [0:0] s1;
  logic [2:0] s2;
  logic d0, d1, d2, f0, f1, f2;
  always #5 CLK = ~CLK;
  rst_seq_sync u0 (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW), .SYNC_RST(s0), .RST_DONE(d0), .SW_RST_FLAG(f0)
  );
  rst_seq_sync #(.NUM_STAGES(2), .HOLD_CYCLES(0), .NUM_OUT(1), .STAGGER_CYCLES(1)) u1 (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW), .SYNC_RST(s1), .RST_DONE(d1), .SW_RST_FLAG(f1)
  );
  rst_seq_sync #(.NUM_STAGES(3), .HOLD_CYCLES(2), .NUM_OUT(3), .STAGGER_CYCLES(3)) u2 (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW), .SYNC_RST(s2), .RST_DONE(d2), .SW_RST_FLAG(f2)
  );
  localparam int PN [3] = '{2, 2, 3};
  localparam int PH [3] = '{4, 0, 2};
  localparam int PO [3] = '{2, 1, 3};
  localparam int PS [3] = '{2, 1, 3};
  int e = 0;
  int last_sw [3] = '{-1, -1, -1};
  int total = 0, bad = 0;
  // Reference: e counts clock edges since RST went high; last_sw holds the
  // last edge a software request was accepted (only after the chain is done).
  always @(posedge CLK or negedge RST)
    if (!RST) begin
      e = 0;
      for (int i = 0; i < 3; i++) last_sw[i] = -1;
    end else begin
      e = e + 1;
      for (int i = 0; i < 3; i++) if (SW && e > PN[i]) last_sw[i] = e;
    end
  function automatic logic [7:0] exp_sync(input int i, input int ee, input int ls);
    int base;
    logic [7:0] r;
    base = ls < 0 ? PN[i] + PH[i] : ls + 1 + PH[i];
    r = '0;
    for (int k = 0; k < PO[i]; k++) r[k] = (ee > 0) && (ee >= base + k * PS[i]);
    return r;
  endfunction
  function automatic logic [7:0] exp_done(input int i, input logic [7:0] x);
    return {7'b0, x == ((8'd1 << PO[i]) - 8'd1)};
  endfunction
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h want=%h", tag, e, got, want);
    end
  endtask
  task automatic check_all();
    logic [7:0] x0, x1, x2;
    x0 = exp_sync(0, e, last_sw[0]);
    x1 = exp_sync(1, e, last_sw[1]);
    x2 = exp_sync(2, e, last_sw[2]);
    check("u0_sync", {6'b0, s0}, x0);
    check("u0_done", {7'b0, d0}, exp_done(0, x0));
    check("u0_flag", {7'b0, f0}, {7'b0, last_sw[0] >= 0});
    check("u1_sync", {7'b0, s1}, x1);
    check("u1_done", {7'b0, d1}, exp_done(1, x1));
    check("u1_flag", {7'b0, f1}, {7'b0, last_sw[1] >= 0});
    check("u2_sync", {5'b0, s2}, x2);
    check("u2_done", {7'b0, d2}, exp_done(2, x2));
    check("u2_flag", {7'b0, f2}, {7'b0, last_sw[2] >= 0});
  endtask
  task automatic run(input int n, input int lo, input int hi, input bit rnd);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      check_all();
      SW = rnd ? ($urandom_range(0, 5) == 0) : (e + 1 >= lo && e + 1 <= hi);
    end
  endtask
  task automatic restart();
    @(negedge CLK);
    SW  = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    check_all();
    RST = 1'b1;
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    check_all();
    RST = 1'b1;
    run(40, 20, 20, 1'b0);
    restart();
    run(45, 20, 29, 1'b0);
    restart();
    run(20, 7, 7, 1'b0);
    restart();
    run(7, 4, 4, 1'b0);
    #1 RST = 1'b0;
    #1 check_all();
    @(posedge CLK);
    #3 RST = 1'b1;
    run(20, 0, -1, 1'b0);
    repeat (6) begin
      restart();
      run(60, 0, 0, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
